pe_controller: RTL

- Sequencer for one PE datapath (filter buffer, 16:1 tap mux, MAC, 4-deep output shift register, mod-4 group counter, OFM).
- Per job: loads a 16-byte kernel, then for each output clears the MAC and accumulates 16 taps against a streamed input byte.
- Shifts each result into the shift register and writes one 4-output word to OFM per group; signals done at job end.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_tap_sequencer.sv | 30 +++
 rtl/pe_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE controller.
package pe_pkg;

  localparam int TAPS      = 16;
  localparam int LANES     = 4;
  localparam int GROUP     = 4;
  localparam int PE_ADDR_W = 32;
  localparam int SEL_W     = $clog2(TAPS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLR,
    MAC,
    SHIFT,
    PAD,
    WRITE,
    FIN
  } state_t;

endpackage

// File: rtl/pe_tap_sequencer.sv
// Tap/beat index counter: advances only on accepted beats and holds through stalls.
module pe_tap_sequencer
  import pe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [SEL_W-1:0] cnt,
  output logic             last_tap,
  output logic             last_beat
);

  localparam logic [SEL_W-1:0] LAST_TAP  = SEL_W'(TAPS - 1);
  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(TAPS / LANES - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= cnt + SEL_W'(1);
    end
  end

  assign last_tap  = (cnt == LAST_TAP);
  assign last_beat = (cnt == LAST_BEAT);

endmodule

// File: rtl/pe_controller.sv
// Sequencer for one PE datapath: kernel load, per-output MAC, grouped OFM writes.
// Optional stall counter output enabled by defining PE_CTRL_PERF_EN.
module pe_controller
  import pe_pkg::*;
#(
  parameter int ADDR_W = PE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       num_outputs,
  input  logic              kernel_valid,
  output logic              kernel_ready,
  input  logic              ifm_valid,
  output logic              ifm_ready,
  input  logic              cout4,
  output logic [TAPS-1:0]   en1,
  output logic [SEL_W-1:0]  sel,
  output logic              en2,
  output logic              rst2,
  output logic              en3,
  output logic              en4,
  output logic              rst4,
  output logic              wr,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       number,
  output logic              done,
  output logic              busy
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  state_t             state, state_n;
  logic               pad_ph;
  logic [31:0]        out_cnt;
  logic [31:0]        number_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               seq_clr, seq_adv, last_tap, last_beat;
  logic [SEL_W-1:0]   seq_cnt;

  logic [TAPS-1:0]    o_en1;
  logic [SEL_W-1:0]   o_sel;
  logic               o_kready, o_iready, o_en2, o_rst2, o_en3, o_en4, o_rst4;
  logic               o_wr, o_done;

  pe_tap_sequencer u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (seq_clr),
    .adv       (seq_adv),
    .cnt       (seq_cnt),
    .last_tap  (last_tap),
    .last_beat (last_beat)
  );

  always_comb begin
    state_n  = state;
    seq_clr  = 1'b0;
    seq_adv  = 1'b0;
    o_en1    = '0;
    o_sel    = '0;
    o_kready = 1'b0;
    o_iready = 1'b0;
    o_en2    = 1'b0;
    o_rst2   = 1'b0;
    o_en3    = 1'b0;
    o_en4    = 1'b0;
    o_rst4   = 1'b0;
    o_wr     = 1'b0;
    o_done   = 1'b0;
    case (state)
      IDLE: begin
        o_rst4  = 1'b1;
        seq_clr = 1'b1;
        if (start) state_n = (num_outputs == 32'd0) ? FIN : LOAD;
      end
      LOAD: begin
        o_kready = 1'b1;
        if (kernel_valid) begin
          o_en1   = {{(TAPS-LANES){1'b0}}, {LANES{1'b1}}} << (LANES * int'(seq_cnt));
          seq_adv = 1'b1;
          if (last_beat) state_n = CLR;
        end
      end
      CLR: begin
        o_rst2  = 1'b1;
        seq_clr = 1'b1;
        state_n = MAC;
      end
      MAC: begin
        o_iready = 1'b1;
        o_en2    = ifm_valid;
        o_sel    = seq_cnt;
        seq_adv  = ifm_valid;
        if (ifm_valid && last_tap) state_n = SHIFT;
      end
      SHIFT: begin
        o_en3 = 1'b1;
        o_en4 = 1'b1;
        if (cout4)                                state_n = WRITE;
        else if (out_cnt + 32'd1 == number_q)     state_n = PAD;
        else                                      state_n = CLR;
      end
      PAD: begin
        // Alternate a MAC clear with a shift so zeros fill the partial group.
        if (!pad_ph) begin
          o_rst2 = 1'b1;
        end else begin
          o_en3 = 1'b1;
          o_en4 = 1'b1;
          if (cout4) state_n = WRITE;
        end
      end
      WRITE: begin
        o_wr    = 1'b1;
        state_n = (out_cnt == number_q) ? FIN : CLR;
      end
      FIN: begin
        o_done  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pad_ph   <= 1'b0;
      out_cnt  <= '0;
      number_q <= '0;
      addr_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          number_q <= num_outputs;
          addr_q   <= '0;
          out_cnt  <= '0;
        end
        SHIFT: begin
          out_cnt <= out_cnt + 32'd1;
          pad_ph  <= 1'b0;
        end
        PAD:     pad_ph <= ~pad_ph;
        WRITE:   addr_q <= addr_q + ADDR_W'(1);
        default: ;
      endcase
    end
  end

`ifdef PE_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (state == IDLE && start) begin
      stall_q <= '0;
    end else if (state == MAC && !ifm_valid && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? stall_q : '0;
`endif

  // Every output reads as zero while reset is held, so an abort never leaks a strobe.
  assign en1          = rst ? o_en1    : '0;
  assign sel          = rst ? o_sel    : '0;
  assign kernel_ready = rst & o_kready;
  assign ifm_ready    = rst & o_iready;
  assign en2          = rst & o_en2;
  assign rst2         = rst & o_rst2;
  assign en3          = rst & o_en3;
  assign en4          = rst & o_en4;
  assign rst4         = rst & o_rst4;
  assign wr           = rst & o_wr;
  assign done         = rst & o_done;
  assign busy         = rst & (state != IDLE);
  assign addr         = rst ? addr_q   : '0;
  assign number       = rst ? number_q : '0;

endmodule
